exe_shifter_pipe: RTL and testbench

EXE_SHIFTER_PIPE -- requirements
Module: exe_shifter_pipe

---
 rtl/exe_shift_pkg.sv | 41 ++++
 rtl/exe_shift_core.sv | 116 +++++++++++
 rtl/exe_shifter_pipe.sv | 114 +++++++++++
 tb/tb_exe_shifter_pipe.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/exe_shift_pkg.sv
// Shared types for the execute-stage shifter pipeline: shift-type encoding,
// decoded operation kind and the stage-1 operation record.
package exe_shift_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    typedef enum logic [1:0] {
        OP_MEM     = 2'b00,  // offset pass-through
        OP_IMM_ROT = 2'b01,  // 8-bit immediate rotated by 2*rot
        OP_RRX     = 2'b10,  // rotate right through carry by one
        OP_SHIFT   = 2'b11   // LSL/LSR/ASR/ROR by a normalised amount
    } op_kind_t;

    typedef struct packed {
        op_kind_t    kind;
        shift_t      sh;
        logic [11:0] operand;
        logic        c_in;
    } s1_op_t;

    // Priority: mem_sel, then imm, then the RRX special case of the
    // immediate-amount form (ROR #0); everything else is a plain shift.
    function automatic op_kind_t decode_kind(input logic        mem_sel,
                                             input logic        imm,
                                             input logic        by_reg,
                                             input logic [11:0] operand);
        if (mem_sel)
            return OP_MEM;
        if (imm)
            return OP_IMM_ROT;
        if (!by_reg && operand[11:7] == 5'd0 && operand[6:5] == 2'b11)
            return OP_RRX;
        return OP_SHIFT;
    endfunction

endpackage

// File: rtl/exe_shift_core.sv
// Combinational barrel shifter with carry-out. The amount arrives already
// normalised: immediate LSR/ASR #0 becomes DATA_W, immediate-rotate amounts
// are already doubled, and register amounts are zero-extended.
module exe_shift_core
    import exe_shift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NW     = 8
) (
    input  s1_op_t            op_i,
    input  logic [NW-1:0]     amt_i,
    input  logic [DATA_W-1:0] rm_i,
    output logic [DATA_W-1:0] value_o,
    output logic              carry_o
);

    localparam int LOG_W = $clog2(DATA_W);

    logic [LOG_W-1:0]     s;
    logic                 amt_zero;
    logic                 amt_eq;
    logic                 amt_big;
    logic [DATA_W:0]      lsl_w;
    logic [DATA_W:0]      lsr_w;
    logic [DATA_W:0]      asr_w;
    logic [DATA_W+11:0]   mem_ext;
    logic [DATA_W+7:0]    imm_ext;

    function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x,
                                               input logic [LOG_W-1:0]  r);
        logic [LOG_W:0] l;
        if (r == '0)
            return x;
        l = (LOG_W+1)'(DATA_W) - {1'b0, r};
        return (x >> r) | (x << l);
    endfunction

    // Low bits give the in-range shift and the rotate amount mod DATA_W; the
    // one-bit-wider shifts expose the last bit shifted out as the carry.
    assign s        = amt_i[LOG_W-1:0];
    assign amt_zero = (amt_i == '0);
    assign amt_eq   = (amt_i == NW'(DATA_W));
    assign amt_big  = (amt_i >  NW'(DATA_W));
    assign lsl_w    = {1'b0, rm_i} << s;
    assign lsr_w    = {rm_i, 1'b0} >> s;
    assign asr_w    = $signed({rm_i, 1'b0}) >>> s;
    assign mem_ext  = {{DATA_W{1'b0}}, op_i.operand};
    assign imm_ext  = {{DATA_W{1'b0}}, op_i.operand[7:0]};

    // Select result and carry by operation kind, then by shift type.
    always_comb begin
        value_o = '0;
        carry_o = op_i.c_in;
        case (op_i.kind)
            OP_MEM: begin
                value_o = mem_ext[DATA_W-1:0];
                carry_o = op_i.c_in;
            end
            OP_IMM_ROT: begin
                value_o = rotr(imm_ext[DATA_W-1:0], s);
                carry_o = (s != '0) ? value_o[DATA_W-1] : op_i.c_in;
            end
            OP_RRX: begin
                value_o = {op_i.c_in, rm_i[DATA_W-1:1]};
                carry_o = rm_i[0];
            end
            default: begin
                if (amt_zero) begin
                    value_o = rm_i;
                    carry_o = op_i.c_in;
                end else begin
                    case (op_i.sh)
                        SH_LSL: begin
                            if (amt_big) begin
                                value_o = '0;
                                carry_o = 1'b0;
                            end else if (amt_eq) begin
                                value_o = '0;
                                carry_o = rm_i[0];
                            end else begin
                                value_o = lsl_w[DATA_W-1:0];
                                carry_o = lsl_w[DATA_W];
                            end
                        end
                        SH_LSR: begin
                            if (amt_big) begin
                                value_o = '0;
                                carry_o = 1'b0;
                            end else if (amt_eq) begin
                                value_o = '0;
                                carry_o = rm_i[DATA_W-1];
                            end else begin
                                value_o = lsr_w[DATA_W:1];
                                carry_o = lsr_w[0];
                            end
                        end
                        SH_ASR: begin
                            if (amt_big || amt_eq) begin
                                value_o = {DATA_W{rm_i[DATA_W-1]}};
                                carry_o = rm_i[DATA_W-1];
                            end else begin
                                value_o = asr_w[DATA_W:1];
                                carry_o = asr_w[0];
                            end
                        end
                        default: begin
                            value_o = rotr(rm_i, s);
                            carry_o = value_o[DATA_W-1];
                        end
                    endcase
                end
            end
        endcase
    end

endmodule

// File: rtl/exe_shifter_pipe.sv
// Two-stage elastic operand-2 shifter: S1 holds the decoded operation and
// normalised amount, S2 holds value2/c_out. Each stage loads whenever the
// stage downstream of it is empty or draining.
module exe_shifter_pipe
    import exe_shift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [11:0]       shift_operand,
    input  logic              imm,
    input  logic              by_reg,
    input  logic              mem_sel,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [AMT_W-1:0]  val_rs,
    input  logic              c_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] value2,
    output logic              c_out
);

    // Wide enough for any register amount and for the value DATA_W itself.
    localparam int NW = (AMT_W > 7) ? AMT_W : 7;

    logic              s1_valid_q;
    s1_op_t            s1_op_q;
    s1_op_t            s1_op_d;
    logic [NW-1:0]     s1_amt_q;
    logic [NW-1:0]     s1_amt_d;
    logic [DATA_W-1:0] s1_rm_q;
    logic              s2_valid_q;
    logic [DATA_W-1:0] value2_q;
    logic [DATA_W-1:0] value2_d;
    logic              c_out_q;
    logic              c_out_d;
    logic              s2_adv;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;

    // Decode the request into an operation kind and a single shift amount.
    always_comb begin
        s1_op_d.kind    = decode_kind(mem_sel, imm, by_reg, shift_operand);
        s1_op_d.sh      = shift_t'(shift_operand[6:5]);
        s1_op_d.operand = shift_operand;
        s1_op_d.c_in    = c_in;
        s1_amt_d        = '0;
        if (s1_op_d.kind == OP_IMM_ROT) begin
            s1_amt_d[4:0] = {shift_operand[11:8], 1'b0};
        end else if (by_reg) begin
            s1_amt_d[AMT_W-1:0] = val_rs;
        end else if (shift_operand[11:7] == 5'd0 &&
                     (s1_op_d.sh == SH_LSR || s1_op_d.sh == SH_ASR)) begin
            s1_amt_d = NW'(DATA_W);
        end else begin
            s1_amt_d[4:0] = shift_operand[11:7];
        end
    end

    // Stage 1: capture only on handshake so idle inputs never leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_amt_q   <= '0;
            s1_rm_q    <= '0;
        end else begin
            if (in_ready)
                s1_valid_q <= in_valid;
            if (in_valid && in_ready) begin
                s1_op_q  <= s1_op_d;
                s1_amt_q <= s1_amt_d;
                s1_rm_q  <= val_rm;
            end
        end
    end

    exe_shift_core #(
        .DATA_W (DATA_W),
        .NW     (NW)
    ) u_core (
        .op_i    (s1_op_q),
        .amt_i   (s1_amt_q),
        .rm_i    (s1_rm_q),
        .value_o (value2_d),
        .carry_o (c_out_d)
    );

    // Stage 2: result holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            value2_q   <= '0;
            c_out_q    <= 1'b0;
        end else begin
            if (s2_adv)
                s2_valid_q <= s1_valid_q;
            if (s1_valid_q && s2_adv) begin
                value2_q <= value2_d;
                c_out_q  <= c_out_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign value2    = value2_q;
    assign c_out     = c_out_q;

endmodule

// File: tb/tb_exe_shifter_pipe.sv
// Directed bench for exe_shifter_pipe with hand-computed expectations.
module tb_exe_shifter_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] shift_operand = '0;
    logic        imm = 1'b0;
    logic        by_reg = 1'b0;
    logic        mem_sel = 1'b0;
    logic [31:0] val_rm = '0;
    logic [7:0]  val_rs = '0;
    logic        c_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] value2;
    logic        c_out;

    int n_checks = 0;
    int n_fail   = 0;

    exe_shifter_pipe #(.DATA_W(32), .AMT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .shift_operand (shift_operand),
        .imm           (imm),
        .by_reg        (by_reg),
        .mem_sel       (mem_sel),
        .val_rm        (val_rm),
        .val_rs        (val_rs),
        .c_in          (c_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .value2        (value2),
        .c_out         (c_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One request with out_ready high; result must appear exactly two cycles
    // after the cycle in which it is offered and accepted.
    task automatic run_op(input string tag, input logic [11:0] op, input logic im,
                          input logic br, input logic ms, input logic [31:0] rm,
                          input logic [7:0] rs, input logic ci,
                          input logic [31:0] exp_v, input logic exp_c);
        @(posedge clk); #1;
        in_valid = 1'b1; shift_operand = op; imm = im; by_reg = br; mem_sel = ms;
        val_rm = rm; val_rs = rs; c_in = ci; out_ready = 1'b1;
        @(negedge clk);
        check_eq({tag, "/in_ready"}, {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; shift_operand = 12'hFFF; imm = 1'b1; by_reg = 1'b1;
        mem_sel = 1'b1; val_rm = 32'hFFFF_FFFF; val_rs = 8'hFF; c_in = ~ci;
        @(negedge clk);
        check_eq({tag, "/lat1"}, {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check_eq({tag, "/valid"}, {63'd0, out_valid}, 64'd1);
        check_eq({tag, "/value2"}, {32'd0, value2}, {32'd0, exp_v});
        check_eq({tag, "/c_out"}, {63'd0, c_out}, {63'd0, exp_c});
        $display("txn %s: value2=0x%08h c_out=%0d", tag, value2, c_out);
    endtask

    logic [31:0] rm_tab  [8] = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 32'h60, 32'h70, 32'h80};
    logic [31:0] exp_tab [8] = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  sent;
        int  recv;
        int  occ;
        logic acc;
        logic dlv;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_eq("rst/out_valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst/value2", {32'd0, value2}, 64'd0);
        check_eq("rst/c_out", {63'd0, c_out}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst/in_ready", {63'd0, in_ready}, 64'd1);
        check_eq("rst/out_valid_rel", {63'd0, out_valid}, 64'd0);

        // Directed vectors: tag, operand, imm, by_reg, mem_sel, rm, rs, c_in, value2, c_out
        run_op("imm_rot_4ff",  12'h4FF, 1, 0, 0, 32'h0000_0000, 8'd0,  0, 32'hFF00_0000, 1);
        run_op("imm_rot_101",  12'h101, 1, 0, 0, 32'h0000_0000, 8'd0,  1, 32'h4000_0000, 0);
        run_op("imm_rot_zero", 12'h0AB, 1, 0, 0, 32'h0000_0000, 8'd0,  1, 32'h0000_00AB, 1);
        run_op("mem_prio",     12'hABC, 1, 1, 1, 32'h1234_5678, 8'd3,  1, 32'h0000_0ABC, 1);
        run_op("asr_reg_40",   12'h040, 0, 1, 0, 32'h8000_0000, 8'd40, 0, 32'hFFFF_FFFF, 1);
        run_op("rrx",          12'h060, 0, 0, 0, 32'h0000_0003, 8'd0,  1, 32'h8000_0001, 1);
        run_op("lsl_reg_32",   12'h000, 0, 1, 0, 32'h0000_0001, 8'd32, 0, 32'h0000_0000, 1);
        run_op("lsl_reg_33",   12'h000, 0, 1, 0, 32'h0000_0001, 8'd33, 1, 32'h0000_0000, 0);
        run_op("lsl_imm_4",    12'h200, 0, 0, 0, 32'hF000_000F, 8'd0,  0, 32'h0000_00F0, 1);
        run_op("lsl_imm_0",    12'h000, 0, 0, 0, 32'hDEAD_BEEF, 8'd0,  0, 32'hDEAD_BEEF, 0);
        run_op("lsr_imm_0",    12'h020, 0, 0, 0, 32'h8000_0000, 8'd0,  0, 32'h0000_0000, 1);
        run_op("asr_imm_0",    12'h040, 0, 0, 0, 32'h8000_0001, 8'd0,  0, 32'hFFFF_FFFF, 1);
        run_op("lsr_reg_1",    12'h020, 0, 1, 0, 32'h0000_0003, 8'd1,  0, 32'h0000_0001, 1);
        run_op("lsr_reg_32",   12'h020, 0, 1, 0, 32'h8000_0000, 8'd32, 0, 32'h0000_0000, 1);
        run_op("asr_reg_4",    12'h040, 0, 1, 0, 32'h8000_0010, 8'd4,  1, 32'hF800_0001, 0);
        run_op("asr_reg_5",    12'h040, 0, 1, 0, 32'h8000_0010, 8'd5,  0, 32'hFC00_0000, 1);
        run_op("ror_reg_0",    12'h060, 0, 1, 0, 32'h1234_5678, 8'd0,  1, 32'h1234_5678, 1);
        run_op("ror_reg_4",    12'h060, 0, 1, 0, 32'h1234_5678, 8'd4,  0, 32'h8123_4567, 1);
        run_op("ror_reg_32",   12'h060, 0, 1, 0, 32'h8000_0001, 8'd32, 0, 32'h8000_0001, 1);

        // Back-to-back stream, LSR by register 4, out_ready low in cycles 3..6
        sent = 0; recv = 0; occ = 0; acc = 1'b0; dlv = 1'b0;
        for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
            @(posedge clk);
            sent += int'(acc);
            recv += int'(dlv);
            occ  += int'(acc) - int'(dlv);
            #1;
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid  = (sent < 8);
            shift_operand = 12'h020; imm = 1'b0; by_reg = 1'b1; mem_sel = 1'b0;
            val_rs = 8'd4; c_in = 1'b1;
            val_rm = (sent < 8) ? rm_tab[sent] : 32'hFFFF_FFFF;
            @(negedge clk);
            check_eq("stream/in_ready", {63'd0, in_ready},
                     {63'd0, !(occ == 2 && !out_ready)});
            acc = in_valid & in_ready;
            dlv = out_valid & out_ready;
            if (out_valid) begin
                if (recv < 8) begin
                    check_eq("stream/value2", {32'd0, value2}, {32'd0, exp_tab[recv]});
                    check_eq("stream/c_out", {63'd0, c_out}, 64'd0);
                    if (dlv)
                        $display("txn stream[%0d]: value2=0x%08h c_out=%0d", recv, value2, c_out);
                end else begin
                    check_eq("stream/extra_out", {63'd0, out_valid}, 64'd0);
                end
            end
        end
        if (dlv) recv += 1;
        check_eq("stream/count", 64'(recv), 64'd8);
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Reset with two requests in flight
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; by_reg = 1'b1; shift_operand = 12'h000;
        val_rm = 32'h1; val_rs = 8'd1;
        @(posedge clk); #1;
        val_rm = 32'h2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("flush/pre_valid", {63'd0, out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("flush/rst_valid", {63'd0, out_valid}, 64'd0);
        check_eq("flush/rst_value2", {32'd0, value2}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("flush/post_valid", {63'd0, out_valid}, 64'd0);
        end
        $display("txn flush: no output after reset release");
        run_op("post_flush",   12'h060, 0, 1, 0, 32'h0000_00F1, 8'd4,  0, 32'h1000_000F, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
